// File: rtl/match_sequencer.sv
// Pong match flow controller: idle -> serve -> rally -> point/pause -> ... -> game over.
// Optional build macro RALLY_SPEEDUP_EN derives a speed level from the rally hit count.
module match_sequencer #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 200,
  parameter int POINT_TICKS = 100,
  parameter int GOAL_LEFT   = 10,
  parameter int GOAL_RIGHT  = 630
) (
  input  logic       clk,
  input  logic       sysResetN,
  input  logic       tickEn,
  input  logic       startBtn,
  input  logic       pauseBtn,
  input  logic [9:0] ballX1,
  input  logic [9:0] ballX2,
  input  logic       ballDirRight,
  output logic       ballHold,
  output logic       ballRun,
  output logic       serveRight,
  output logic [3:0] p1Score,
  output logic [3:0] p2Score,
  output logic [7:0] rallyHits,
  output logic [1:0] speedLevel,
  output logic       gameOver,
  output logic       winner,
  output logic [2:0] stateOut
);

  localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);

  localparam logic [TW-1:0] SERVE_T = TW'(SERVE_TICKS);
  localparam logic [TW-1:0] POINT_T = TW'(POINT_TICKS);
  localparam logic [TW-1:0] TIMER_1 = TW'(1);
  localparam logic [3:0]    WIN     = 4'(WIN_SCORE);
  localparam logic [9:0]    GOAL_L  = 10'(GOAL_LEFT);
  localparam logic [9:0]    GOAL_R  = 10'(GOAL_RIGHT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_e;

  state_e        state;
  logic [TW-1:0] timer;
  logic          start_prev, pause_prev;
  logic          start_edge, pause_edge;
  logic          dir_prev;

  assign stateOut = state;

  // NOTE: history resets to 1 so a button already held when reset releases
  // does not look like a fresh press.
  always_ff @(posedge clk or negedge sysResetN) begin
    if (!sysResetN) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      start_edge <= 1'b0;
      pause_edge <= 1'b0;
      dir_prev   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic so each register
      // samples the pre-edge value of its neighbours.
      start_prev <= startBtn;
      pause_prev <= pauseBtn;
      start_edge <= startBtn & ~start_prev;
      pause_edge <= pauseBtn & ~pause_prev;
      dir_prev   <= ballDirRight;
    end
  end

  always_ff @(posedge clk or negedge sysResetN) begin
    if (!sysResetN) begin
      state      <= IDLE;
      timer      <= '0;
      ballHold   <= 1'b1;
      ballRun    <= 1'b0;
      serveRight <= 1'b0;
      p1Score    <= '0;
      p2Score    <= '0;
      rallyHits  <= '0;
      gameOver   <= 1'b0;
      winner     <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start_edge) begin
            state    <= SERVE;
            timer    <= SERVE_T;
            p1Score  <= '0;
            p2Score  <= '0;
            gameOver <= 1'b0;
            winner   <= 1'b0;
            ballHold <= 1'b1;
            ballRun  <= 1'b0;
          end
        end

        SERVE: begin
          if (tickEn) begin
            if (timer == TIMER_1) begin
              state     <= RALLY;
              timer     <= '0;
              rallyHits <= '0;
              ballHold  <= 1'b0;
              ballRun   <= 1'b1;
            end else begin
              timer <= timer - TIMER_1;
            end
          end
        end

        RALLY: begin
          if (ballDirRight != dir_prev && rallyHits != 8'hFF)
            rallyHits <= rallyHits + 8'd1;

          // Left goal is checked first so a simultaneous double goal scores once.
          if (ballX1 <= GOAL_L) begin
            p2Score    <= p2Score + 4'd1;
            serveRight <= 1'b0;
            ballHold   <= 1'b1;
            ballRun    <= 1'b0;
            if (p2Score + 4'd1 == WIN) begin
              state    <= OVER;
              gameOver <= 1'b1;
              winner   <= 1'b1;
            end else begin
              state <= POINT;
              timer <= POINT_T;
            end
          end else if (ballX2 >= GOAL_R) begin
            p1Score    <= p1Score + 4'd1;
            serveRight <= 1'b1;
            ballHold   <= 1'b1;
            ballRun    <= 1'b0;
            if (p1Score + 4'd1 == WIN) begin
              state    <= OVER;
              gameOver <= 1'b1;
              winner   <= 1'b0;
            end else begin
              state <= POINT;
              timer <= POINT_T;
            end
          end else if (pause_edge) begin
            state    <= PAUSE;
            ballHold <= 1'b0;
            ballRun  <= 1'b0;
          end
        end

        PAUSE: begin
          if (pause_edge) begin
            state   <= RALLY;
            ballRun <= 1'b1;
          end
        end

        POINT: begin
          if (tickEn) begin
            if (timer == TIMER_1) begin
              state <= SERVE;
              timer <= SERVE_T;
            end else begin
              timer <= timer - TIMER_1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          ballHold <= 1'b1;
          ballRun  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RALLY_SPEEDUP_EN
  always_ff @(posedge clk or negedge sysResetN) begin
    if (!sysResetN)
      speedLevel <= '0;
    else if (rallyHits[7:4] != 4'd0)
      speedLevel <= 2'd3;
    else
      speedLevel <= rallyHits[3:2];
  end
`else
  assign speedLevel = 2'd0;
`endif

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: reset, serve countdown, goals, pause, win and restart.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       sysResetN;
  logic       tickEn;
  logic       startBtn;
  logic       pauseBtn;
  logic [9:0] ballX1;
  logic [9:0] ballX2;
  logic       ballDirRight;
  logic       ballHold;
  logic       ballRun;
  logic       serveRight;
  logic [3:0] p1Score;
  logic [3:0] p2Score;
  logic [7:0] rallyHits;
  logic [1:0] speedLevel;
  logic       gameOver;
  logic       winner;
  logic [2:0] stateOut;

  int n_checks = 0;
  int n_errors = 0;

  localparam int S_IDLE = 0, S_SERVE = 1, S_RALLY = 2, S_PAUSE = 3, S_POINT = 4, S_OVER = 5;

  match_sequencer dut (
    .clk         (clk),
    .sysResetN   (sysResetN),
    .tickEn      (tickEn),
    .startBtn    (startBtn),
    .pauseBtn    (pauseBtn),
    .ballX1      (ballX1),
    .ballX2      (ballX2),
    .ballDirRight(ballDirRight),
    .ballHold    (ballHold),
    .ballRun     (ballRun),
    .serveRight  (serveRight),
    .p1Score     (p1Score),
    .p2Score     (p2Score),
    .rallyHits   (rallyHits),
    .speedLevel  (speedLevel),
    .gameOver    (gameOver),
    .winner      (winner),
    .stateOut    (stateOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tickEn = 1'b1;
      cyc(1);
      tickEn = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press_start();
    startBtn = 1'b0;
    cyc(1);
    startBtn = 1'b1;
    cyc(2);
  endtask

  task automatic press_pause();
    pauseBtn = 1'b1;
    cyc(2);
    pauseBtn = 1'b0;
  endtask

  initial begin
    sysResetN    = 1'b0;
    tickEn       = 1'b0;
    startBtn     = 1'b1;
    pauseBtn     = 1'b0;
    ballX1       = 10'd320;
    ballX2       = 10'd340;
    ballDirRight = 1'b0;
    cyc(3);
    sysResetN = 1'b1;
    cyc(5);

    // Start held through reset must not start a match.
    check("rst_state", stateOut, S_IDLE);
    check("rst_hold", ballHold, 1);
    check("rst_run", ballRun, 0);
    check("rst_p1", p1Score, 0);
    check("rst_p2", p2Score, 0);
    check("rst_over", gameOver, 0);
    check("rst_speed", speedLevel, 0);
    check("rst_hits", rallyHits, 0);

    press_start();
    check("start_serve", stateOut, S_SERVE);
    check("serve_hold", ballHold, 1);

    ticks(199);
    check("serve_199", stateOut, S_SERVE);
    ticks(1);
    check("serve_200", stateOut, S_RALLY);
    check("rally_run", ballRun, 1);
    check("rally_hold", ballHold, 0);
    check("rally_hits0", rallyHits, 0);

    // Right goal scores once for player 1 even while held.
    ballX2 = 10'd630;
    cyc(1);
    check("goal_r_state", stateOut, S_POINT);
    check("goal_r_p1", p1Score, 1);
    check("goal_r_serve", serveRight, 1);
    cyc(50);
    check("goal_r_held_p1", p1Score, 1);
    ballX2 = 10'd340;
    ticks(99);
    check("point_99", stateOut, S_POINT);
    ticks(1);
    check("point_100", stateOut, S_SERVE);

    // Start edges are ignored while serving.
    press_start();
    check("serve_ign_start", stateOut, S_SERVE);
    ticks(200);
    check("rally2", stateOut, S_RALLY);

    press_pause();
    check("pause_state", stateOut, S_PAUSE);
    check("pause_run", ballRun, 0);
    check("pause_hold", ballHold, 0);
    ballX1 = 10'd0;
    ticks(5);
    check("pause_p2", p2Score, 0);
    check("pause_stay", stateOut, S_PAUSE);
    ballX1 = 10'd320;
    cyc(1);
    press_pause();
    check("unpause_state", stateOut, S_RALLY);
    check("unpause_run", ballRun, 1);

    repeat (9) begin
      ballDirRight = ~ballDirRight;
      cyc(2);
    end
    cyc(1);
    check("hits9", rallyHits, 9);
`ifdef RALLY_SPEEDUP_EN
    check("speed_hits9", speedLevel, 2);
`else
    check("speed_hits9", speedLevel, 0);
`endif

    // Goal and pause edge reach the controller on the same cycle: goal wins.
    pauseBtn = 1'b1;
    cyc(1);
    ballX1 = 10'd5;
    cyc(1);
    ballX1 = 10'd320;
    pauseBtn = 1'b0;
    check("gp_state", stateOut, S_POINT);
    check("gp_p2", p2Score, 1);
    check("gp_serve", serveRight, 0);
    cyc(3);
    check("gp_stay", stateOut, S_POINT);

    ticks(100);
    ticks(200);
    check("next_rally", stateOut, S_RALLY);
    check("next_hits0", rallyHits, 0);
    cyc(1);
    check("next_speed0", speedLevel, 0);

    // Player 2 scores up to 8.
    repeat (7) begin
      ballX1 = 10'd5;
      cyc(1);
      ballX1 = 10'd320;
      ticks(100);
      ticks(200);
    end
    check("p2_is8", p2Score, 8);
    check("p2_8_rally", stateOut, S_RALLY);

    ballX1 = 10'd5;
    cyc(1);
    ballX1 = 10'd320;
    check("win_state", stateOut, S_OVER);
    check("win_p2", p2Score, 9);
    check("win_over", gameOver, 1);
    check("win_winner", winner, 1);
    ballX2 = 10'd630;
    cyc(3);
    ballX2 = 10'd340;
    check("over_p1_hold", p1Score, 1);
    check("over_stay", stateOut, S_OVER);
    check("over_ballhold", ballHold, 1);

    press_start();
    check("restart_state", stateOut, S_SERVE);
    check("restart_p1", p1Score, 0);
    check("restart_p2", p2Score, 0);
    check("restart_over", gameOver, 0);
    check("restart_winner", winner, 0);

    // Goal thresholds are inclusive; left wins a double goal.
    ticks(200);
    ballX1 = 10'd11;
    ballX2 = 10'd629;
    cyc(3);
    check("edge_nogoal_state", stateOut, S_RALLY);
    check("edge_nogoal_p2", p2Score, 0);
    ballX1 = 10'd10;
    ballX2 = 10'd630;
    cyc(1);
    check("both_p2", p2Score, 1);
    check("both_p1", p1Score, 0);
    check("both_serve", serveRight, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
